op_result_arbiter: RTL and testbench
====================================

// Module: op_result_arbiter
// PURPOSE
//  Shares the single co-processor output module between NUM_OPS operation units.
//  Each unit presents a result with the STB/BUSY handshake (producer raises STB and
//  holds data until it sees STB=1 && BUSY=0 on a clock edge). The arbiter grants one
//  unit per transfer, registers the result, and forwards it downstream with a source
//  tag over the same handshake.
// PARAMETERS
//  NUM_OPS  4   number of requesting operation units (>=2)
//  DATA_W   16  result width (bfloat16 results, e.g. 16'h3F80 = 1.0)
//  TAG_W    $clog2(NUM_OPS) localparam; width of the source tag and round-robin pointer
// PORTS
//  clk                  in   1                clock
//  rst                  in   1                synchronous, active-low reset
//  op_output_STB        in   NUM_OPS          result strobe, bit i from unit i
//  op_output_x          in   NUM_OPS*DATA_W   results; unit i on [i*DATA_W +: DATA_W]
//  op_output_BUSY       out  NUM_OPS          busy to unit i; low only on its accept cycle
//  out_STB              out  1                forwarded result valid (registered)
//  out_x                out  DATA_W           forwarded result (registered)
//  out_tag              out  TAG_W            index of unit that produced out_x
//  output_module_BUSY   in   1                downstream busy; transfer when out_STB && !BUSY
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE, out_STB=0, out_x=0, out_tag=0, rr_ptr=0.
//    While rst==0, op_output_BUSY is all ones, so no result is accepted or lost.
//  - FSM states:
//    IDLE: grant = first set bit of op_output_STB, searching from rr_ptr upward and
//      wrapping at NUM_OPS-1 -> 0. op_output_BUSY is combinational: bit grant is 0,
//      all other bits are 1. With no request, all bits are 1. On the edge with a valid
//      grant: capture out_x <= data[grant], out_tag <= grant, out_STB <= 1,
//      rr_ptr <= (grant==NUM_OPS-1) ? 0 : grant+1, and go to SEND.
//    SEND: op_output_BUSY is all ones. out_STB, out_x and out_tag are held stable.
//      On the edge with output_module_BUSY==0: out_STB <= 0, go to IDLE.
//  - Latency: request accepted at edge T; out_STB high from T+1. If downstream is not
//    busy, out_STB drops at T+2. Peak throughput is one result per 2 cycles.
//  - Only the granted unit's data is sampled; other units keep STB and data until their
//    own grant. A unit that drops STB before its grant is simply not selected.
//  - STB raised in the same cycle as a grant to another unit waits for the next IDLE.
//  - Starvation-free: a waiting unit is served within NUM_OPS transfers.
//  - Reset taking effect in SEND discards the held result without completing it:
//    out_STB=0 on the next cycle and rr_ptr restarts at 0.
//  - out_x is never modified; width is passed through.
// CONFIGURATION
//  OPARB_FIXED_PRIORITY_EN defined: rr_ptr is removed. The grant is the lowest set index
//    of op_output_STB (unit 0 highest priority). A continuously requesting low index
//    may starve higher indices.
//  Not defined (default): round-robin as described above.
// TESTING (NUM_OPS=4, DATA_W=16)
//  1. Only unit 2 requests, x=16'h3F80, downstream idle:
//     -> BUSY=4'b1011 at T; at T+1 out_STB=1, out_x=16'h3F80, out_tag=2; out_STB=0 at T+2.
//  2. All 4 request at once after reset, data 16'h0001..16'h0004, downstream idle:
//     -> out_tag sequence 0,1,2,3 with matching data, one grant per 2 cycles.
//  3. rr_ptr=3, units 0 and 3 request -> unit 3 is served first, then unit 0 (wrap).
//  4. output_module_BUSY=1 for 5 cycles during SEND, unit 1 requesting
//     -> out_STB, out_x and out_tag stable; BUSY=4'b1111 throughout; unit 1 granted
//     only after the transfer completes.
//  5. rst=0 while in SEND with out_STB=1 -> next cycle out_STB=0, out_x=0, out_tag=0;
//     BUSY=4'b1111 during reset; pending requests re-arbitrated from unit 0 after release.
//  6. OPARB_FIXED_PRIORITY_EN defined, units 0 and 2 request continuously
//     -> out_tag is always 0; unit 2 is never granted.

Source files
------------

// File: rtl/op_result_arbiter.sv
// Arbitrates NUM_OPS STB/BUSY result producers onto one registered output port.
// Define OPARB_FIXED_PRIORITY_EN for lowest-index-first instead of round-robin.
module op_result_arbiter #(
   parameter  int NUM_OPS = 4,
   parameter  int DATA_W  = 16,
   localparam int TAG_W   = $clog2(NUM_OPS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_OPS-1:0]        op_output_STB,
   input  logic [NUM_OPS*DATA_W-1:0] op_output_x,
   output logic [NUM_OPS-1:0]        op_output_BUSY,
   output logic                      out_STB,
   output logic [DATA_W-1:0]         out_x,
   output logic [TAG_W-1:0]          out_tag,
   input  logic                      output_module_BUSY
);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [DATA_W-1:0]   op_data [NUM_OPS];
   logic [TAG_W-1:0]    gnt;
   logic                gnt_vld;
   logic                stb_nxt;
   logic [DATA_W-1:0]   x_nxt;
   logic [TAG_W-1:0]    tag_nxt;

   for (genvar i = 0; i < NUM_OPS; i++) begin : g_unpack
      assign op_data[i] = op_output_x[i*DATA_W +: DATA_W];
   end

`ifdef OPARB_FIXED_PRIORITY_EN
   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int k = NUM_OPS - 1; k >= 0; k--) begin
         if (op_output_STB[k]) begin
            gnt     = TAG_W'(k);
            gnt_vld = 1'b1;
         end
      end
   end
`else
   logic [TAG_W-1:0] rr_ptr;
   logic [TAG_W-1:0] rr_nxt;
   logic [TAG_W-1:0] cand;

   // Downward scan of offsets: the smallest offset from rr_ptr wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int k = NUM_OPS - 1; k >= 0; k--) begin
         if (int'(rr_ptr) + k >= NUM_OPS)
            cand = TAG_W'(int'(rr_ptr) + k - NUM_OPS);
         else
            cand = TAG_W'(int'(rr_ptr) + k);
         if (op_output_STB[cand]) begin
            gnt     = cand;
            gnt_vld = 1'b1;
         end
      end
   end

   assign rr_nxt = (gnt == TAG_W'(NUM_OPS - 1)) ? '0 : gnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst)
         rr_ptr <= '0;
      else if (state == IDLE && gnt_vld)
         rr_ptr <= rr_nxt;
   end
`endif

   always_comb begin
      state_nxt      = state;
      stb_nxt        = out_STB;
      x_nxt          = out_x;
      tag_nxt        = out_tag;
      op_output_BUSY = '1;
      unique case (1'b1)
         (state == IDLE): begin
            if (gnt_vld) begin
               op_output_BUSY[gnt] = 1'b0;
               stb_nxt             = 1'b1;
               x_nxt               = op_data[gnt];
               tag_nxt             = gnt;
               state_nxt           = SEND;
            end
         end
         (state == SEND): begin
            if (!output_module_BUSY) begin
               stb_nxt   = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Nothing may be accepted while reset is asserted.
      if (!rst)
         op_output_BUSY = '1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         out_STB <= 1'b0;
         out_x   <= '0;
         out_tag <= '0;
      end else begin
         state   <= state_nxt;
         out_STB <= stb_nxt;
         out_x   <= x_nxt;
         out_tag <= tag_nxt;
      end
   end

endmodule

// File: tb/tb_op_result_arbiter.sv
// Self-checking bench for op_result_arbiter: vector table plus scoreboard.
// Producers are modelled as per-unit queues honouring STB/BUSY.
module tb_op_result_arbiter;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   stb;
   logic [N*W-1:0] xin;
   logic [N-1:0]   busy;
   logic           out_stb;
   logic [W-1:0]   out_x;
   logic [1:0]     out_tag;
   logic           obusy;

   always #5 clk = ~clk;

   op_result_arbiter #(
      .NUM_OPS (N),
      .DATA_W  (W)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .op_output_STB      (stb),
      .op_output_x        (xin),
      .op_output_BUSY     (busy),
      .out_STB            (out_stb),
      .out_x              (out_x),
      .out_tag            (out_tag),
      .output_module_BUSY (obusy)
   );

   typedef struct packed {
      logic [1:0]  tag;
      logic [15:0] x;
   } exp_t;

   typedef struct {
      int          unit;
      logic [15:0] x;
      logic [3:0]  busy;
   } vec_t;

   exp_t        sb [$];
   logic [15:0] pend [N][$];
   int          errors = 0;
   int          checks = 0;
   int          xfers  = 0;
   logic [3:0]  s_busy;
   logic        s_stb;
   logic [15:0] s_x;
   logic [1:0]  s_tag;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         stb[i] = pend[i].size() > 0;
         xin[i*W +: W] = stb[i] ? pend[i][0] : 16'h0000;
      end
   endtask

   task automatic cyc();
      logic [N-1:0] acc;
      exp_t         e;
      @(negedge clk);
      s_busy = busy;
      s_stb  = out_stb;
      s_x    = out_x;
      s_tag  = out_tag;
      acc    = rst ? (stb & ~busy) : '0;
      if (rst && out_stb && !obusy) begin
         xfers++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got tag %0d x %h expected none",
                     out_tag, out_x);
         end else begin
            e = sb.pop_front();
            chk("sb_tag", 32'(out_tag), 32'(e.tag));
            chk("sb_x", 32'(out_x), 32'(e.x));
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (acc[i]) void'(pend[i].pop_front());
      drive();
   endtask

   task automatic req(input int u, input logic [15:0] d, input bit exp);
      exp_t e;
      pend[u].push_back(d);
      if (exp) begin
         e.tag = 2'(u);
         e.x   = d;
         sb.push_back(e);
      end
      drive();
   endtask

   task automatic drain(input int max, input string nm);
      for (int i = 0; i < max && sb.size() > 0; i++)
         cyc();
      cyc();
      chk(nm, 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) cyc();
      rst = 1'b1;
   endtask

   vec_t vecs [5];
   int   x0;
   exp_t e6;

   initial begin
      vecs[0] = '{2, 16'h3F80, 4'b1011};
      vecs[1] = '{0, 16'hBF80, 4'b1110};
      vecs[2] = '{3, 16'h7F80, 4'b0111};
      vecs[3] = '{1, 16'hFFFF, 4'b1101};
      vecs[4] = '{0, 16'h0000, 4'b1110};

      rst   = 1'b0;
      obusy = 1'b0;
      stb   = '0;
      xin   = '0;

      // reset with a request already present
      req(0, 16'h5555, 1'b1);
      cyc();
      chk("rst_busy0", 32'(s_busy), 32'hF);
      cyc();
      chk("rst_busy", 32'(s_busy), 32'hF);
      chk("rst_stb", 32'(s_stb), 32'd0);
      chk("rst_x", 32'(s_x), 32'd0);
      chk("rst_tag", 32'(s_tag), 32'd0);
      rst = 1'b1;
      drain(10, "rst_drain");

      // single-request vectors
      for (int v = 0; v < 5; v++) begin
         req(vecs[v].unit, vecs[v].x, 1'b1);
         cyc();
         chk("vec_busy", 32'(s_busy), 32'(vecs[v].busy));
         cyc();
         chk("vec_stb1", 32'(s_stb), 32'd1);
         chk("vec_tag", 32'(s_tag), 32'(vecs[v].unit));
         chk("vec_x", 32'(s_x), 32'(vecs[v].x));
         cyc();
         chk("vec_stb0", 32'(s_stb), 32'd0);
      end

      // all four at once after reset: 0,1,2,3 at one per two cycles
      do_reset(2);
      for (int u = 0; u < N; u++)
         req(u, 16'(u + 1), 1'b1);
      x0 = xfers;
      repeat (8) cyc();
      chk("all4_rate", 32'(xfers - x0), 32'd4);
      chk("all4_sb", 32'(sb.size()), 32'd0);

      // wrap: move rr_ptr to 3, then units 0 and 3
      req(2, 16'h2222, 1'b1);
      drain(10, "wrap_pre");
`ifdef OPARB_FIXED_PRIORITY_EN
      req(0, 16'h0A0A, 1'b1);
      req(3, 16'h3B3B, 1'b1);
`else
      req(3, 16'h3B3B, 1'b1);
      req(0, 16'h0A0A, 1'b1);
`endif
      drain(10, "wrap");

      // downstream stall during SEND with unit 1 waiting
      obusy = 1'b1;
      req(0, 16'hAAAA, 1'b1);
      cyc();
      req(1, 16'hBBBB, 1'b1);
      repeat (5) begin
         cyc();
         chk("stall_stb", 32'(s_stb), 32'd1);
         chk("stall_tag", 32'(s_tag), 32'd0);
         chk("stall_x", 32'(s_x), 32'hAAAA);
         chk("stall_busy", 32'(s_busy), 32'hF);
      end
      obusy = 1'b0;
      cyc();
      cyc();
      chk("stall_next_busy", 32'(s_busy), 32'hD);
      cyc();
      chk("stall_next_tag", 32'(s_tag), 32'd1);
      drain(10, "stall");

      // reset in SEND discards the held result, rr restarts at 0
      obusy = 1'b1;
      req(2, 16'hCCCC, 1'b0);
      cyc();
      req(1, 16'h1010, 1'b1);
      req(3, 16'h3030, 1'b1);
      cyc();
      chk("rsend_stb", 32'(s_stb), 32'd1);
      chk("rsend_tag", 32'(s_tag), 32'd2);
      rst = 1'b0;
      cyc();
      chk("rsend_busy_a", 32'(s_busy), 32'hF);
      cyc();
      chk("rsend_stb0", 32'(s_stb), 32'd0);
      chk("rsend_x0", 32'(s_x), 32'd0);
      chk("rsend_tag0", 32'(s_tag), 32'd0);
      chk("rsend_busy_b", 32'(s_busy), 32'hF);
      rst   = 1'b1;
      obusy = 1'b0;
      cyc();
      chk("rsend_regrant", 32'(s_busy), 32'hD);
      drain(10, "rsend");

      // units 0 and 2 requesting continuously
      for (int k = 0; k < 6; k++) begin
         pend[0].push_back(16'h0600 + 16'(k));
         pend[2].push_back(16'h2600 + 16'(k));
      end
`ifdef OPARB_FIXED_PRIORITY_EN
      for (int k = 0; k < 6; k++) begin
         e6.tag = 2'd0;
         e6.x   = 16'h0600 + 16'(k);
         sb.push_back(e6);
      end
      for (int k = 0; k < 6; k++) begin
         e6.tag = 2'd2;
         e6.x   = 16'h2600 + 16'(k);
         sb.push_back(e6);
      end
`else
      for (int k = 0; k < 6; k++) begin
         e6.tag = 2'd0;
         e6.x   = 16'h0600 + 16'(k);
         sb.push_back(e6);
         e6.tag = 2'd2;
         e6.x   = 16'h2600 + 16'(k);
         sb.push_back(e6);
      end
`endif
      drive();
      repeat (12) cyc();
`ifdef OPARB_FIXED_PRIORITY_EN
      chk("cont_u2_left", 32'(pend[2].size()), 32'd6);
`else
      chk("cont_u2_left", 32'(pend[2].size()), 32'd3);
`endif
      drain(40, "cont");

      for (int u = 0; u < N; u++)
         chk("pend_empty", 32'(pend[u].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
